// File: rtl/flag_pkg.sv
// Shared types and constants for the NZCV condition-flag producer.
package flag_pkg;

    // Bit order {n,z,c,v} matches the condition checker's Flags input.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // ALUControl encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // FlagW bit positions.
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/flag_calc.sv
// Combinational N/Z/C/V generation from the execute-stage operands.
// C/V are only meaningful for ADD/SUB; logical ops report 0 and the
// writer never commits them.
module flag_calc
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output flags_t           calc
);

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] b_op;

    // Derive flags; SUB is formed as A + ~B + 1 so C=1 means no borrow.
    always_comb begin
        calc.n = alu_result[WIDTH-1];
        calc.z = (alu_result == {WIDTH{1'b0}});
        calc.c = 1'b0;
        calc.v = 1'b0;
        b_op   = {WIDTH{1'b0}};
        ext    = {(WIDTH+1){1'b0}};
        case (alu_control)
            ALU_ADD: begin
                b_op   = src_b;
                ext    = {1'b0, src_a} + {1'b0, b_op};
                calc.c = ext[WIDTH];
                calc.v = (src_a[WIDTH-1] == src_b[WIDTH-1]) &
                         (ext[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                b_op   = ~src_b;
                ext    = {1'b0, src_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, 1'b1};
                calc.c = ext[WIDTH];
                calc.v = (src_a[WIDTH-1] != src_b[WIDTH-1]) &
                         (ext[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND, ALU_ORR: begin
                calc.c = 1'b0;
                calc.v = 1'b0;
            end
            default: begin
                calc.c = 1'b0;
                calc.v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/flag_writer.sv
// Architectural NZCV flag register with gated ALU writes, a zero-bubble
// next-flags bypass and a one-entry saved-flags register.
module flag_writer
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [1:0]       FlagW,
    input  logic             CondEx,
    input  logic             SaveFlags,
    input  logic             RestoreFlags,
    output logic [3:0]       Flags,
    output logic [3:0]       FlagsNext,
    output logic [3:0]       SavedFlags,
    output logic             FlagUpdated
);

    flags_t calc;
    flags_t flags_q;
    flags_t saved_q;
    flags_t flags_d;
    flags_t saved_d;
    logic   updated_q;
    logic   updated_d;
    logic   wr_nz;
    logic   wr_cv;

    flag_calc #(.WIDTH(WIDTH)) u_calc (
        .src_a       (SrcA),
        .src_b       (SrcB),
        .alu_control (ALUControl),
        .alu_result  (ALUResult),
        .calc        (calc)
    );

    // Logical ops never touch C/V, so FlagW[0] is masked for them.
    assign wr_nz = Valid & CondEx & FlagW[FLAGW_NZ];
    assign wr_cv = Valid & CondEx & FlagW[FLAGW_CV] & ~ALUControl[1];

    // Next-state: reset > restore > per-half ALU write > hold.
    always_comb begin
        flags_d   = flags_q;
        saved_d   = saved_q;
        updated_d = 1'b0;
        if (reset) begin
            flags_d = 4'b0000;
            saved_d = 4'b0000;
        end else if (RestoreFlags) begin
            flags_d = saved_q;
            if (SaveFlags) begin
                saved_d = flags_q;
            end else begin
                saved_d = saved_q;
            end
        end else begin
            if (wr_nz) begin
                flags_d.n = calc.n;
                flags_d.z = calc.z;
            end else begin
                flags_d.n = flags_q.n;
                flags_d.z = flags_q.z;
            end
            if (wr_cv) begin
                flags_d.c = calc.c;
                flags_d.v = calc.v;
            end else begin
                flags_d.c = flags_q.c;
                flags_d.v = flags_q.v;
            end
            if (SaveFlags) begin
                saved_d = flags_q;
            end else begin
                saved_d = saved_q;
            end
            updated_d = (wr_nz | wr_cv) & (flags_d != flags_q);
        end
    end

    // Flag, saved-flag and update-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            saved_q   <= 4'b0000;
            updated_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            saved_q   <= saved_d;
            updated_q <= updated_d;
        end
    end

    assign Flags       = flags_q;
    assign SavedFlags  = saved_q;
    assign FlagUpdated = updated_q;
    assign FlagsNext   = flags_d;

endmodule

// File: tb/tb_flag_writer.sv
// Directed self-checking bench for flag_writer.
module tb_flag_writer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             Valid;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [1:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic [1:0]       FlagW;
    logic             CondEx;
    logic             SaveFlags;
    logic             RestoreFlags;
    logic [3:0]       Flags;
    logic [3:0]       FlagsNext;
    logic [3:0]       SavedFlags;
    logic             FlagUpdated;

    int errors = 0;
    int checks = 0;

    flag_writer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .Valid        (Valid),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .ALUControl   (ALUControl),
        .ALUResult    (ALUResult),
        .FlagW        (FlagW),
        .CondEx       (CondEx),
        .SaveFlags    (SaveFlags),
        .RestoreFlags (RestoreFlags),
        .Flags        (Flags),
        .FlagsNext    (FlagsNext),
        .SavedFlags   (SavedFlags),
        .FlagUpdated  (FlagUpdated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r,
                       input logic [1:0] fw);
        Valid      = 1'b1;
        CondEx     = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        ALUResult  = r;
        FlagW      = fw;
    endtask

    initial begin
        reset = 1'b1; Valid = 1'b0; CondEx = 1'b0; SrcA = 32'h0; SrcB = 32'h0;
        ALUControl = 2'b00; ALUResult = 32'h0; FlagW = 2'b00;
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
        #1;
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_saved", SavedFlags, 4'b0000);
        chk("reset_upd", {3'b000, FlagUpdated}, 4'b0000);
        tick(); tick();
        reset = 1'b0;

        // ADD overflow into sign bit
        alu(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 2'b11);
        #1; chk("add_ovf_next", FlagsNext, 4'b1001);
        tick();
        chk("add_ovf_flags", Flags, 4'b1001);
        chk("add_ovf_upd", {3'b000, FlagUpdated}, 4'b0001);

        // SUB 5-5 = 0
        alu(2'b01, 32'd5, 32'd5, 32'h0, 2'b11);
        tick();
        chk("sub_zero", Flags, 4'b0110);
        // SUB 0-1 borrow
        alu(2'b01, 32'd0, 32'd1, 32'hFFFFFFFF, 2'b11);
        tick();
        chk("sub_borrow", Flags, 4'b1000);
        alu(2'b01, 32'd5, 32'd5, 32'h0, 2'b11);
        tick();
        chk("sub_zero2", Flags, 4'b0110);

        // CondEx=0 then Valid=0 block writes
        alu(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 2'b11);
        CondEx = 1'b0;
        #1; chk("condex0_next", FlagsNext, 4'b0110);
        tick();
        chk("condex0_flags", Flags, 4'b0110);
        chk("condex0_upd", {3'b000, FlagUpdated}, 4'b0000);
        CondEx = 1'b1; Valid = 1'b0;
        tick();
        chk("valid0_flags", Flags, 4'b0110);
        chk("valid0_upd", {3'b000, FlagUpdated}, 4'b0000);
        // X operands with enables off
        SrcA = 'x; SrcB = 'x; ALUControl = 'x; ALUResult = 'x;
        #1; chk("x_next", FlagsNext, 4'b0110);
        tick();
        chk("x_flags", Flags, 4'b0110);

        // Build Flags=0011: CV-only ADD then NZ-only ORR
        alu(2'b00, 32'h80000000, 32'h80000000, 32'h0, 2'b01);
        tick();
        chk("cv_only", Flags, 4'b0111);
        alu(2'b11, 32'd1, 32'd0, 32'd1, 2'b10);
        tick();
        chk("nz_only", Flags, 4'b0011);
        // AND sets Z, C/V held
        alu(2'b10, 32'h000000F0, 32'h0000000F, 32'h0, 2'b11);
        tick();
        chk("and_flags", Flags, 4'b0111);
        chk("and_upd", {3'b000, FlagUpdated}, 4'b0001);
        // AND with only FlagW[0] writes nothing
        alu(2'b10, 32'h00000001, 32'h00000001, 32'h1, 2'b01);
        tick();
        chk("and_cv_ignored", Flags, 4'b0111);
        chk("and_cv_upd", {3'b000, FlagUpdated}, 4'b0000);

        // Save uses pre-edge value
        alu(2'b01, 32'd5, 32'd5, 32'h0, 2'b11);
        tick();
        alu(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 2'b11);
        SaveFlags = 1'b1;
        tick();
        SaveFlags = 1'b0;
        chk("save_flags", Flags, 4'b1001);
        chk("save_saved", SavedFlags, 4'b0110);

        // Swap with concurrent ALU write dropped
        alu(2'b01, 32'd0, 32'd1, 32'hFFFFFFFF, 2'b11);
        SaveFlags = 1'b1; RestoreFlags = 1'b1;
        #1; chk("swap_next", FlagsNext, 4'b0110);
        tick();
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
        chk("swap_flags", Flags, 4'b0110);
        chk("swap_saved", SavedFlags, 4'b1001);
        chk("swap_upd", {3'b000, FlagUpdated}, 4'b0000);

        // Make FlagUpdated=1, then reset mid-cycle with a write pending
        alu(2'b11, 32'd1, 32'd0, 32'd1, 2'b10);
        tick();
        chk("pre_reset_flags", Flags, 4'b0010);
        chk("pre_reset_upd", {3'b000, FlagUpdated}, 4'b0001);
        alu(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 2'b11);
        SaveFlags = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_flags", Flags, 4'b0000);
        chk("async_saved", SavedFlags, 4'b0000);
        chk("async_upd", {3'b000, FlagUpdated}, 4'b0000);
        tick();
        chk("held_flags", Flags, 4'b0000);
        chk("held_saved", SavedFlags, 4'b0000);
        chk("held_upd", {3'b000, FlagUpdated}, 4'b0000);
        reset = 1'b0; SaveFlags = 1'b0;
        tick();
        chk("post_reset_flags", Flags, 4'b1001);
        chk("post_reset_saved", SavedFlags, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
